// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encodings, handshake FSM
// states and opcode classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_INV0  = 4'b1110,
        OP_INV1  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Operations handled by the iterative multiply/divide unit.
    function automatic logic is_multicycle(input opcode_e op);
        case (op)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Divide-class operations (quotient or remainder).
    function automatic logic is_divide(input opcode_e op);
        case (op)
            OP_DIVU, OP_REMU: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) unit.
// Runs exactly XLEN iterations after start; done is asserted during the
// last iteration with result already reflecting that iteration.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  opcode_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  cnt_r;
    opcode_e           op_r;
    logic [2*XLEN-1:0] acc_r;   // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   m_r;     // multiplicand or divisor

    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_nxt_s;
    logic [XLEN:0]     trial_s;  // shifted partial remainder, one bit wider than XLEN
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   rem_nxt_s;
    logic [XLEN-1:0]   quo_nxt_s;

    // One shift-add step and one restoring-divide step from the current state.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]}
                  + (acc_r[0] ? {1'b0, m_r} : {(XLEN+1){1'b0}});
        mul_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        trial_s   = {rem_r, acc_r[XLEN-1]};
        diff_s    = trial_s - {1'b0, m_r};
        if (diff_s[XLEN]) begin
            rem_nxt_s = trial_s[XLEN-1:0];
            quo_nxt_s = {acc_r[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt_s = diff_s[XLEN-1:0];
            quo_nxt_s = {acc_r[XLEN-2:0], 1'b1};
        end
    end

    // Select the final value for the latched operation.
    always_comb begin
        case (op_r)
            OP_MUL:   result = mul_nxt_s[XLEN-1:0];
            OP_MULHU: result = mul_nxt_s[2*XLEN-1:XLEN];
            OP_DIVU:  result = quo_nxt_s;
            OP_REMU:  result = rem_nxt_s;
            default:  result = {XLEN{1'b0}};
        endcase
    end

    assign done = (cnt_r == CNT_W'(1));

    // Load operands on start, then iterate until the counter drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            op_r  <= OP_MUL;
            acc_r <= {(2*XLEN){1'b0}};
            rem_r <= {XLEN{1'b0}};
            m_r   <= {XLEN{1'b0}};
        end else if (start) begin
            cnt_r <= CNT_W'(XLEN);
            op_r  <= op;
            rem_r <= {XLEN{1'b0}};
            if (is_divide(op)) begin
                acc_r <= {{XLEN{1'b0}}, a};
                m_r   <= b;
            end else begin
                acc_r <= {{XLEN{1'b0}}, b};
                m_r   <= a;
            end
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (is_divide(op_r)) begin
                acc_r <= {acc_r[2*XLEN-1:XLEN], quo_nxt_s};
                rem_r <= rem_nxt_s;
            end else begin
                acc_r <= mul_nxt_s;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: valid/ready handshake FSM, single-cycle datapath,
// and registered result/zero/err outputs.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err,
    output logic            busy
);

    state_e            state_r;
    state_e            state_nxt_s;
    opcode_e           op_s;
    logic              accept_s;
    logic              launch_md_s;
    logic              start_s;
    logic              load_single_s;
    logic              load_md_s;
    logic [XLEN-1:0]   single_res_s;
    logic              single_err_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic              md_done_s;
    logic [XLEN-1:0]   md_result_s;

    assign op_s      = opcode_e'(opcode);
    assign shamt_s   = b[SHAMT_W-1:0];
    assign accept_s  = in_valid & in_ready;
    // A zero divisor is resolved in the single-cycle path.
    assign launch_md_s = is_multicycle(op_s) & ~(is_divide(op_s) & (b == {XLEN{1'b0}}));
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_BUSY);

    // Ready in IDLE, or in DONE when the pending result is being taken.
    always_comb begin
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Single-cycle operations, including the divide-by-zero results.
    always_comb begin
        single_err_s = 1'b0;
        case (op_s)
            OP_ADD:   single_res_s = a + b;
            OP_SUB:   single_res_s = a - b;
            OP_AND:   single_res_s = a & b;
            OP_OR:    single_res_s = a | b;
            OP_XOR:   single_res_s = a ^ b;
            OP_SLT:   single_res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  single_res_s = {{(XLEN-1){1'b0}}, (a < b)};
            OP_SLL:   single_res_s = a << shamt_s;
            OP_SRL:   single_res_s = a >> shamt_s;
            OP_SRA:   single_res_s = $unsigned($signed(a) >>> shamt_s);
            OP_DIVU:  single_res_s = {XLEN{1'b1}};
            OP_REMU:  single_res_s = a;
            OP_MUL,
            OP_MULHU: single_res_s = {XLEN{1'b0}};
            default: begin
                single_res_s = {XLEN{1'b0}};
                single_err_s = 1'b1;
            end
        endcase
    end

    // Handshake FSM next state and datapath load strobes.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        load_single_s = 1'b0;
        load_md_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (launch_md_s) begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        load_single_s = 1'b1;
                        state_nxt_s   = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    load_md_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept_s) begin
                        if (launch_md_s) begin
                            start_s     = 1'b1;
                            state_nxt_s = ST_BUSY;
                        end else begin
                            load_single_s = 1'b1;
                            state_nxt_s   = ST_DONE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output registers: result, zero and err always update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= {XLEN{1'b0}};
            zero   <= 1'b0;
            err    <= 1'b0;
        end else if (load_single_s) begin
            result <= single_res_s;
            zero   <= (single_res_s == {XLEN{1'b0}});
            err    <= single_err_s;
        end else if (load_md_s) begin
            result <= md_result_s;
            zero   <= (md_result_s == {XLEN{1'b0}});
            err    <= 1'b0;
        end
    end

    alu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .op     (op_s),
        .a      (a),
        .b      (b),
        .done   (md_done_s),
        .result (md_result_s)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (XLEN=32). Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
module tb_alu_mc;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic        busy;

    int vec_cnt;
    int miscmp_cnt;

    alu_mc #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one op at a falling edge (block must be ready), then wait for
    // out_valid, checking busy/in_ready while waiting and the latency.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_err, input int exp_lat);
        int lat;
        opcode    = op;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        lat      = 1;
        in_valid = 1'b0;
        a        = ~x;
        b        = ~y;
        opcode   = 4'h0;
        while (!out_valid && lat < 100) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        vec_cnt    = 0;
        miscmp_cnt = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = 32'd0;
        b          = 32'd0;
        opcode     = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // add 5+7, result valid for exactly one cycle.
        opcode = 4'b0000; a = 32'd5; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_res", result, 32'd12);
        chk("add_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        chk("add_valid_1cyc", {31'd0, out_valid}, 32'd0);

        // Back-to-back sub, slt, sltu.
        opcode = 4'b0001; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        chk("sub_res", result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        opcode = 4'b0101; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);
        chk("slt_res", result, 32'd1);
        chk("slt_valid", {31'd0, out_valid}, 32'd1);
        opcode = 4'b0110;
        @(negedge clk);
        chk("sltu_res", result, 32'd0);
        chk("sltu_zero", {31'd0, zero}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Remaining single-cycle ops.
        run_op("xor",  4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1);
        run_op("and",  4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1);
        run_op("or",   4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1);
        run_op("addw", 4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 1);
        run_op("sll",  4'b0111, 32'd1,         32'h24,        32'h10,        1'b0, 1'b0, 1);
        run_op("srl",  4'b1000, 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0, 1);
        run_op("sra",  4'b1001, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1'b0, 1);
        run_op("inv",  4'b1111, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1);
        run_op("inv0", 4'b1110, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1);

        // Multi-cycle ops and divide-by-zero shortcut.
        run_op("mul",   4'b1010, 32'hFFFF_FFFF, 32'd2,   32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        run_op("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'd2,   32'd1,         1'b0, 1'b0, 33);
        run_op("mul2",  4'b1010, 32'd1000,      32'd1000, 32'h000F_4240, 1'b0, 1'b0, 33);
        run_op("mulh2", 4'b1011, 32'h8000_0000, 32'd4,   32'd2,         1'b0, 1'b0, 33);
        run_op("divu",  4'b1100, 32'd100,       32'd7,   32'd14,        1'b0, 1'b0, 33);
        run_op("remu",  4'b1101, 32'd100,       32'd7,   32'd2,         1'b0, 1'b0, 33);
        run_op("divu2", 4'b1100, 32'hFFFF_FFFF, 32'h10,  32'h0FFF_FFFF, 1'b0, 1'b0, 33);
        run_op("remu2", 4'b1101, 32'hFFFF_FFFF, 32'h10,  32'h0000_000F, 1'b0, 1'b0, 33);
        run_op("remu0r",4'b1101, 32'd6,         32'd7,   32'd6,         1'b0, 1'b0, 33);
        run_op("divu0", 4'b1100, 32'd5,         32'd0,   32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run_op("remu0", 4'b1101, 32'd5,         32'd0,   32'd5,         1'b0, 1'b0, 1);
        @(negedge clk);

        // Reset in the middle of a divide aborts it.
        opcode = 4'b1100; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_inrdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_result", {31'd0, out_valid}, 32'd0);

        // Hold in DONE with out_ready=0; new input ignored until consumed.
        out_ready = 1'b0;
        opcode = 4'b0000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(negedge clk);
        opcode = 4'b0001; a = 32'd1; b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_res", result, 32'd7);
            chk("hold_inrdy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        // Consume and accept the waiting sub in the same cycle.
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("consume_accept_valid", {31'd0, out_valid}, 32'd1);
        chk("consume_accept_res", result, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("consume_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised ALU for the datapath execute stage.
- Supersedes the fixed 32-bit combinational ALU.
- Adds XLEN-generic width, xor/sltu/shift operations, and iterative unsigned multiply/divide.
- Uses a valid/ready handshake on both operand and result sides, so the control unit can stall while long operations run.

## Interface
Parameters:
- XLEN, 32, operand/result width (must be ≥ 4, power of two).
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode present.
- in_ready  out  1  block can accept this cycle.
- a, b  in  XLEN  operands.
- opcode  in  4  operation select.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.
- err  out  1  invalid opcode (result forced 0).
- busy  out  1  multi-cycle op in progress.

## Operation
- Opcodes 0000 to 0101 keep the legacy encodings:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt (signed).
- New opcodes:
  - 0100 xor, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
  - 1010 mul (low XLEN bits of a*b), 1011 mulhu (high XLEN bits, unsigned).
  - 1100 divu, 1101 remu.
- Opcodes 1110 and 1111 are invalid: result=0, err=1, zero=1, single-cycle.
- All arithmetic is modulo 2^XLEN.
- Shifts use b[SHAMT_W-1:0] only.
- slt returns 1 or 0, zero-extended.
- Division by zero: divu returns all-ones, remu returns a. No err, single-cycle.
- FSM states:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) of a single-cycle op registers result and goes to DONE. An accept of a mul/div op with nonzero divisor loads the iterative unit and goes to BUSY.
  - BUSY: in_ready=0, busy=1. Runs one iteration per cycle for exactly XLEN cycles, then latches the result and goes to DONE.
  - DONE: out_valid=1; result, zero and err are stable. If out_ready=1, the result is consumed. Within DONE, in_ready = out_ready.
    - Consume with simultaneous accept: handle the new op exactly as from IDLE.
    - Consume without accept: go to IDLE.
    - out_ready=0: hold all outputs unchanged.
- Operands are captured at accept. Later changes to a/b/opcode have no effect.
- zero and err are registered together with result.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - State IDLE; in_ready=1.
  - out_valid=0, result=0, zero=0, err=0, busy=0.
  - Iteration counter 0.
- Single-cycle ops: accept at edge N; out_valid=1 after edge N+1.
- mul/mulhu/divu/remu: accept at edge N; out_valid=1 after edge N+XLEN+1 (33 cycles for XLEN=32).
- Back-to-back single-cycle ops with out_ready held 1 give one result per cycle.
- Reset asserted in BUSY or DONE aborts the operation: no result is produced and any pending result is lost.
- Multiply: shift-add, one partial product per cycle, 2·XLEN accumulator.
- Divide: restoring, one quotient bit per cycle. Remainder is XLEN+1 bits wide internally.
- While DONE and out_ready=0, in_valid is ignored (in_ready=0).

## Structure
- Package alu_pkg holds:
  - the opcode enum (4 bits, all encodings above);
  - the FSM state enum (IDLE, BUSY, DONE);
  - the helper function is_multicycle(opcode).
- Sub-module alu_muldiv holds the iterative unit:
  - Inputs: start, op (mul/mulhu/divu/remu), a, b.
  - Outputs: done pulse, XLEN-bit result.
  - Contents: its own counter and accumulator.
- The top holds the handshake FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset then add with XLEN=32, a=5, b=7, out_ready=1 -> one cycle later result=12, zero=0, out_valid=1 for exactly one cycle.
- sub a=9, b=9, then slt a=0xFFFFFFFF, b=1, then sltu with the same operands, issued back-to-back -> results 0 (zero=1), 1, 0 on consecutive cycles.
- mul a=0xFFFFFFFF, b=2 -> after 33 cycles result=0xFFFFFFFE. mulhu with the same operands -> result=1. busy=1 throughout, in_ready=0 during BUSY.
- divu a=100, b=7 -> result 14; remu -> 2. divu a=5, b=0 -> 0xFFFFFFFF after 1 cycle; remu a=5, b=0 -> 5.
- sra a=0x80000000, b=0x21 (shamt=1) -> 0xC0000000. Opcode 1111 -> result=0, err=1, zero=1.
- Start divu, assert reset at BUSY cycle 10 -> out_valid=0, busy=0, in_ready=1 immediately. Hold out_ready=0 in DONE for 5 cycles -> result stable, in_valid ignored.
